// File: rtl/alu_pkg.sv
// Shared widths and op bundle for the ALU issue/writeback stage.
package alu_pkg;

  localparam int ALU_DATA_BITS     = 8;
  localparam int ALU_REG_ADDR_BITS = 4;

  typedef logic [ALU_REG_ADDR_BITS-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t                 rd;
    reg_idx_t                 rs1;
    reg_idx_t                 rs2;
    logic                     imm_en;
    logic [ALU_DATA_BITS-1:0] imm;
    logic                     sub;
  } alu_op_t;

  // True when a valid in-flight destination matches a source index.
  function automatic logic idx_hit(input logic v, input reg_idx_t rd, input reg_idx_t rs);
    return v && (rd == rs);
  endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: two async operand reads, one async debug read, one sync write.
module reg_file #(
  parameter int DATA_BITS     = 8,
  parameter int REG_ADDR_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [REG_ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0]     wdata,
  input  logic [REG_ADDR_BITS-1:0] raddr_a,
  output logic [DATA_BITS-1:0]     rdata_a,
  input  logic [REG_ADDR_BITS-1:0] raddr_b,
  output logic [DATA_BITS-1:0]     rdata_b,
  input  logic [REG_ADDR_BITS-1:0] dbg_addr,
  output logic [DATA_BITS-1:0]     dbg_data
);

  logic [DATA_BITS-1:0] mem [2**REG_ADDR_BITS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2**REG_ADDR_BITS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a  = mem[raddr_a];
  assign rdata_b  = mem[raddr_b];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_wb.sv
// Operand issue and writeback stage around a registered ALU.
// ISS holds operands driven to the ALU, EXE tracks the op whose result the ALU presents.
module alu_issue_wb
  import alu_pkg::*;
#(
  parameter int DATA_BITS     = ALU_DATA_BITS,
  parameter int REG_ADDR_BITS = ALU_REG_ADDR_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [REG_ADDR_BITS-1:0] op_rd,
  input  logic [REG_ADDR_BITS-1:0] op_rs1,
  input  logic [REG_ADDR_BITS-1:0] op_rs2,
  input  logic                     op_imm_en,
  input  logic [DATA_BITS-1:0]     op_imm,
  input  logic                     op_sub,
  output logic [DATA_BITS-1:0]     alu_a,
  output logic [DATA_BITS-1:0]     alu_b,
  output logic                     alu_cin,
  input  logic [DATA_BITS-1:0]     alu_result,
  input  logic                     alu_cout,
  input  logic                     alu_zero,
  output logic                     flag_c,
  output logic                     flag_z,
  output logic                     busy,
  input  logic [REG_ADDR_BITS-1:0] dbg_addr,
  output logic [DATA_BITS-1:0]     dbg_data
);

  alu_op_t              op;
  logic                 iss_v, exe_v;
  reg_idx_t             iss_rd, exe_rd;
  logic [DATA_BITS-1:0] rf_a, rf_b, opnd_a, opnd_b;
  logic                 hazard, accept;

  assign op = '{rd: op_rd, rs1: op_rs1, rs2: op_rs2, imm_en: op_imm_en,
                imm: op_imm, sub: op_sub};

  reg_file #(.DATA_BITS(DATA_BITS), .REG_ADDR_BITS(REG_ADDR_BITS)) u_rf (
    .clk      (clk),
    .reset    (reset),
    .we       (exe_v),
    .waddr    (exe_rd),
    .wdata    (alu_result),
    .raddr_a  (op.rs1),
    .rdata_a  (rf_a),
    .raddr_b  (op.rs2),
    .rdata_b  (rf_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // ISS result is not yet available anywhere, so a dependent op must wait one cycle.
  assign hazard   = idx_hit(iss_v, iss_rd, op.rs1) || (!op.imm_en && idx_hit(iss_v, iss_rd, op.rs2));
  assign op_ready = reset && !hazard;
  assign accept   = op_valid && op_ready;

  // EXE result is on alu_result this cycle and is the same value being written back.
  assign opnd_a = idx_hit(exe_v, exe_rd, op.rs1) ? alu_result : rf_a;
  assign opnd_b = op.imm_en                       ? op.imm     :
                  idx_hit(exe_v, exe_rd, op.rs2) ? alu_result : rf_b;

  always_ff @(posedge clk) begin
    if (!reset) begin
      iss_v   <= 1'b0;
      exe_v   <= 1'b0;
      iss_rd  <= '0;
      exe_rd  <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_cin <= 1'b0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
    end else begin
      iss_v <= accept;
      if (accept) begin
        alu_a   <= opnd_a;
        alu_b   <= opnd_b;
        alu_cin <= op.sub;
        iss_rd  <= op.rd;
      end
      exe_v  <= iss_v;
      exe_rd <= iss_rd;
      if (exe_v) begin
        flag_c <= alu_cout;
        flag_z <= alu_zero;
      end
    end
  end

  assign busy = iss_v | exe_v;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Scoreboard bench for alu_issue_wb with a registered ALU model.
module tb_alu_issue_wb;

  localparam int DB = 8;
  localparam int AB = 4;

  logic          clk = 0;
  logic          reset = 0;
  logic          op_valid = 0;
  logic          op_ready;
  logic [AB-1:0] op_rd = '0, op_rs1 = '0, op_rs2 = '0;
  logic          op_imm_en = 0;
  logic [DB-1:0] op_imm = '0;
  logic          op_sub = 0;
  logic [DB-1:0] alu_a, alu_b, alu_result;
  logic          alu_cin, alu_cout, alu_zero;
  logic          flag_c, flag_z, busy;
  logic [AB-1:0] dbg_addr, stim_addr = '0, mon_addr = '0;
  logic          mon_en = 0;
  logic [DB-1:0] dbg_data;

  int passed = 0;
  int total  = 0;
  int edge_n = 0;
  int last_stalls = 0;

  typedef struct {
    logic [AB-1:0] rd;
    logic [DB-1:0] val;
    logic          c;
    logic          z;
    int            wb_edge;
  } exp_t;
  exp_t sb[$];

  assign dbg_addr = mon_en ? mon_addr : stim_addr;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Registered ALU: subtract is a + ~b + 1.
  logic [DB:0] alu_sum;
  assign alu_sum = {1'b0, alu_a} + {1'b0, (alu_cin ? ~alu_b : alu_b)} + {{DB{1'b0}}, alu_cin};
  always @(posedge clk) begin
    alu_result <= alu_sum[DB-1:0];
    alu_cout   <= alu_sum[DB];
    alu_zero   <= (alu_sum[DB-1:0] == '0);
  end

  alu_issue_wb dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_rd(op_rd), .op_rs1(op_rs1), .op_rs2(op_rs2), .op_imm_en(op_imm_en),
    .op_imm(op_imm), .op_sub(op_sub), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cin(alu_cin), .alu_result(alu_result), .alu_cout(alu_cout),
    .alu_zero(alu_zero), .flag_c(flag_c), .flag_z(flag_z), .busy(busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  // Monitor: compare register and flags right after each expected writeback edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].wb_edge < edge_n) begin
        check("wb_missed", edge_n, sb[0].wb_edge);
        void'(sb.pop_front());
      end else if (sb.size() > 0 && sb[0].wb_edge == edge_n) begin
        exp_t e;
        e = sb.pop_front();
        mon_addr = e.rd;
        mon_en   = 1;
        #1;
        check($sformatf("wb_r%0d", e.rd), dbg_data, e.val);
        check($sformatf("flag_c_r%0d", e.rd), flag_c, e.c);
        check($sformatf("flag_z_r%0d", e.rd), flag_z, e.z);
        mon_en = 0;
      end
    end
  end

  task automatic issue(input logic [AB-1:0] rd, input logic [AB-1:0] rs1,
                       input logic [AB-1:0] rs2, input logic imm_en,
                       input logic [DB-1:0] imm, input logic sub,
                       input logic [DB-1:0] ea, input logic [DB-1:0] eb,
                       input logic [DB-1:0] ev, input logic ec, input logic ez);
    int stalls = 0;
    exp_t e;
    @(negedge clk);
    op_rd = rd; op_rs1 = rs1; op_rs2 = rs2; op_imm_en = imm_en;
    op_imm = imm; op_sub = sub; op_valid = 1;
    #1;
    while (!op_ready && stalls < 8) begin
      @(negedge clk); #1; stalls++;
    end
    if (!op_ready) begin
      check($sformatf("accept_timeout_r%0d", rd), 0, 1);
      op_valid = 0;
    end else begin
      e.rd = rd; e.val = ev; e.c = ec; e.z = ez; e.wb_edge = edge_n + 3;
      sb.push_back(e);
      @(posedge clk); #1;
      op_valid = 0;
      check($sformatf("alu_a_r%0d", rd), alu_a, ea);
      check($sformatf("alu_b_r%0d", rd), alu_b, eb);
      check($sformatf("alu_cin_r%0d", rd), alu_cin, sub);
    end
    last_stalls = stalls;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() > 0 || busy) && n < 50) begin
      @(negedge clk); n++;
    end
    check("idle_timeout", (n < 50) ? 1 : 0, 1);
    @(negedge clk); @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    int bad = 0;
    for (int i = 0; i < 2**AB; i++) begin
      stim_addr = AB'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), dbg_data, 0);
    end
    stim_addr = '0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("ready_in_reset", op_ready, 0);
    @(negedge clk);
    reset = 1;
    #1;
    check_all_zero("rst");
    check("rst_flag_c", flag_c, 0);
    check("rst_flag_z", flag_z, 0);
    check("rst_ready", op_ready, 1);
    check("rst_busy", busy, 0);

    // Independent immediates back-to-back, then dependents with bypass.
    issue(4'd1, 4'd0, 4'd0, 1, 8'd5, 0, 8'd0, 8'd5, 8'd5, 0, 0);
    check("busy_active", busy, 1);
    issue(4'd2, 4'd0, 4'd0, 1, 8'd3, 0, 8'd0, 8'd3, 8'd3, 0, 0);
    check("r2_stalls", last_stalls, 0);
    issue(4'd3, 4'd1, 4'd2, 0, 8'd0, 1, 8'd5, 8'd3, 8'd2, 1, 0);
    issue(4'd4, 4'd3, 4'd3, 0, 8'd0, 0, 8'd2, 8'd2, 8'd4, 0, 0);
    check("r4_stalls", last_stalls, 1);
    issue(4'd5, 4'd1, 4'd1, 0, 8'd0, 1, 8'd5, 8'd5, 8'd0, 1, 1);
    check("r5_stalls", last_stalls, 0);
    issue(4'd6, 4'd1, 4'd0, 1, 8'hFF, 0, 8'd5, 8'hFF, 8'h04, 1, 0);
    wait_idle();

    // Reset with one op in EXE and one in ISS: both must vanish.
    issue(4'd7, 4'd1, 4'd0, 1, 8'd1, 0, 8'd5, 8'd1, 8'd6, 0, 0);
    issue(4'd8, 4'd2, 4'd0, 1, 8'd1, 0, 8'd3, 8'd1, 8'd4, 0, 0);
    @(negedge clk);
    reset = 0;
    sb.delete();
    @(posedge clk); #1;
    check("flush_busy", busy, 0);
    check("flush_ready", op_ready, 0);
    check("flush_alu_a", alu_a, 0);
    @(negedge clk);
    reset = 1;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("flush");
    check("flush_flag_c", flag_c, 0);
    check("flush_flag_z", flag_z, 0);

    issue(4'd1, 4'd0, 4'd0, 1, 8'd5, 0, 8'd0, 8'd5, 8'd5, 0, 0);
    check("post_rst_stalls", last_stalls, 0);
    wait_idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: time %0t limit 100000", $time);
    $fatal(1, "timeout");
  end

endmodule
